// File: rtl/pipe_pkg.sv
// Shared fetch-pipeline definitions: fetch FSM states, default constants and helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
  } fetch_word_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: {valid, instr, pc, pcplus4} with load, flush and hold.
module if_id_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [96:0] d,
  output logic [96:0] q
);

  logic [96:0] q_q, q_d;

  // Flush wins over load; a bubble keeps the old pc fields.
  always_comb begin
    q_d = q_q;
    if (flush) begin
      q_d = {1'b0, NOP_INSTR, q_q[63:0]};
    end else if (load) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= {1'b0, NOP_INSTR, 64'h0};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, skid buffer for
// decode stalls, and discard of a stale response after a redirect.
module ifetch_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        isbranchtakenE,
  input  logic [31:0] branchtargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic        validD
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  fetch_word_t  skid_q, skid_d;

  logic        ifid_load, ifid_flush;
  logic [96:0] ifid_din, ifid_q;
  fetch_word_t fetched;
  logic        ifid_free;

  assign fetched   = '{instr: imem_rdata, pc: pc_q, pcplus4: pc_q + 32'd4};
  assign ifid_free = !validD || !stallD;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_din   = {1'b1, fetched};
    if (isbranchtakenE) begin
      pc_d       = word_align(branchtargetE);
      ifid_flush = 1'b1;
      skid_d     = '0;
      // A stale ack arriving alongside a redirect in KILL is consumed here,
      // otherwise KILL would wait for an ack that never comes.
      case (state_q)
        FETCH:   state_d = imem_ack ? FETCH : KILL;
        HOLD:    state_d = FETCH;
        KILL:    state_d = imem_ack ? FETCH : KILL;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            pc_d = fetched.pcplus4;
            if (ifid_free) begin
              ifid_load = 1'b1;
            end else begin
              skid_d  = fetched;
              state_d = HOLD;
            end
          end else if (validD && !stallD) begin
            ifid_flush = 1'b1;
          end
        end
        HOLD: begin
          if (!stallD) begin
            ifid_load = 1'b1;
            ifid_din  = {1'b1, skid_q};
            skid_d    = '0;
            state_d   = FETCH;
          end
        end
        KILL: begin
          if (imem_ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk  (clk),
    .rst  (rst),
    .load (ifid_load),
    .flush(ifid_flush),
    .d    (ifid_din),
    .q    (ifid_q)
  );

  assign {validD, instrD, pcD, pcplus4D} = ifid_q;
  assign imem_req  = rst && (state_q == FETCH);
  assign imem_addr = pc_q;

endmodule
